ddr2_rd_checker: RTL and testbench

//  Downstream consumer of the DDR2 test read path: drains 16-bit words from the read FIFO
//  (rd_en/rd_data, 1-cycle FIFO read latency), compares each against a 16-bit Galois LFSR

---
 rtl/ddr2_rd_checker_pkg.sv | 33 +++
 rtl/ddr2_rd_checker_lfsr16.sv | 32 +++
 rtl/ddr2_rd_checker.sv | 154 +++++++++++++++
 tb/tb_ddr2_rd_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_rd_checker_pkg.sv
// ddr2_rd_checker_pkg: shared types, widths and LFSR defaults for the DDR2 read-path checker.
// The seed/polynomial defaults must match the write-side pattern generator.
package ddr2_rd_checker_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 32;

    localparam logic [DATA_W-1:0] LFSR_SEED_DEF = 16'hACE1;
    localparam logic [DATA_W-1:0] LFSR_POLY_DEF = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Snapshot of the first failing word.
    typedef struct packed {
        logic [CNT_W-1:0]  index;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] act;
    } err_cap_t;

    // One Galois step: shift right, fold taps in when the bit shifted out is 1.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] poly);
        logic [DATA_W-1:0] sh;
        sh = cur >> 1;
        return cur[0] ? (sh ^ poly) : sh;
    endfunction

endpackage

// File: rtl/ddr2_rd_checker_lfsr16.sv
// ddr2_rd_checker_lfsr16: 16-bit Galois LFSR with synchronous load, shared with the write-side generator.
// Ports: clk, reset_n (async, active-low), i_en (advance), i_load (load i_seed, wins over i_en),
//        i_seed (load value), o_q (current LFSR value).
module ddr2_rd_checker_lfsr16
    import ddr2_rd_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = LFSR_SEED_DEF,
    parameter logic [DATA_W-1:0] POLY = LFSR_POLY_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_seed,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= SEED;
        end else if (i_load) begin
            r_q <= i_seed;
        end else if (i_en) begin
            r_q <= lfsr_next(r_q, POLY);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ddr2_rd_checker.sv
// ddr2_rd_checker: drains num_words 16-bit words from the read FIFO (1-cycle read latency),
// compares each against the LFSR pattern, counts words/mismatches and captures the first failure.
// Ports: clk, reset_n (async, active-low); start (pulse), abort (level), num_words (sampled on start);
//        rd_empty/rd_en/rd_data FIFO read side (rd_en is combinational);
//        busy, done, pass, aborted status; word_count, err_count (saturating),
//        first_err_index/first_err_exp/first_err_act capture of the first mismatch.
module ddr2_rd_checker
    import ddr2_rd_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter logic [DATA_W-1:0] LFSR_POLY = LFSR_POLY_DEF,
    parameter int unsigned       ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     num_words,
    input  logic                 rd_empty,
    output logic                 rd_en,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 aborted,
    output logic [CNT_W-1:0]     word_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [CNT_W-1:0]     first_err_index,
    output logic [DATA_W-1:0]    first_err_exp,
    output logic [DATA_W-1:0]    first_err_act
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 w_rd_en;
    logic                 w_launch;
    logic                 w_finish;
    logic                 r_vld_d;
    logic [CNT_W-1:0]     r_num_words;
    logic [CNT_W-1:0]     r_issued;
    logic [CNT_W-1:0]     r_word_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_aborted;
    err_cap_t             r_cap;
    logic [DATA_W-1:0]    w_lfsr;
    logic                 w_mismatch;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, FIFO pop and run launch/finish strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd_en = !rd_empty && (r_issued != r_num_words) && !abort;
                if (abort || ((r_issued + CNT_W'(w_rd_en)) == r_num_words)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_vld_d) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_mismatch = r_vld_d && (rd_data != w_lfsr);

    // Issue/compare counters, error accounting and first-failure capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_d     <= 1'b0;
            r_num_words <= '0;
            r_issued    <= '0;
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
            r_aborted   <= 1'b0;
            r_cap       <= '0;
        end else begin
            r_vld_d <= w_rd_en;
            if (w_launch) begin
                r_num_words <= num_words;
                r_issued    <= '0;
                r_word_cnt  <= '0;
                r_err_cnt   <= '0;
                r_aborted   <= 1'b0;
                r_cap       <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + CNT_W'(1);
                end
                if (r_vld_d) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
                if (w_mismatch) begin
                    if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                    end
                    if (r_err_cnt == '0) begin
                        r_cap <= '{index: r_word_cnt, exp: w_lfsr, act: rd_data};
                    end
                end
                // Only an abort can bring us to DRAIN with reads still owed.
                if (w_finish) begin
                    r_aborted <= (r_issued != r_num_words);
                end
            end
        end
    end

    // Expected-pattern source: reseeded on launch, advanced once per compared word.
    ddr2_rd_checker_lfsr16 #(
        .SEED (LFSR_SEED),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (r_vld_d && !w_launch),
        .i_load  (w_launch),
        .i_seed  (LFSR_SEED),
        .o_q     (w_lfsr)
    );

    assign rd_en           = w_rd_en;
    assign busy            = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done            = (r_state == ST_DONE);
    assign pass            = done && (r_err_cnt == '0) && !r_aborted;
    assign aborted         = r_aborted;
    assign word_count      = r_word_cnt;
    assign err_count       = r_err_cnt;
    assign first_err_index = r_cap.index;
    assign first_err_exp   = r_cap.exp;
    assign first_err_act   = r_cap.act;

endmodule

// File: tb/tb_ddr2_rd_checker.sv
// tb_ddr2_rd_checker: table-driven and randomized bench for ddr2_rd_checker with a queue-based
// FIFO model (1-cycle read latency) and a reference pattern model.
module tb_ddr2_rd_checker;

    localparam int unsigned ERR_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [31:0]      num_words;
    logic             rd_empty;
    logic             rd_en;
    logic [15:0]      rd_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic             aborted;
    logic [31:0]      word_count;
    logic [ERR_W-1:0] err_count;
    logic [31:0]      first_err_index;
    logic [15:0]      first_err_exp;
    logic [15:0]      first_err_act;

    int          checks = 0;
    int          errors = 0;
    int          pops;
    bit          hole;
    int unsigned stall_pct;
    logic [15:0] fifo_q[$];

    typedef struct {
        int          nw;
        int          corrupt;
        int          abort_after;
        int unsigned spct;
        int          hole_at;
        bit          e_pass;
        int          e_wc;
        int          e_err;
        bit          e_ab;
    } vec_t;

    vec_t vecs[9];

    ddr2_rd_checker #(.ERR_CNT_W(ERR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .num_words       (num_words),
        .rd_empty        (rd_empty),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .aborted         (aborted),
        .word_count      (word_count),
        .err_count       (err_count),
        .first_err_index (first_err_index),
        .first_err_exp   (first_err_exp),
        .first_err_act   (first_err_act)
    );

    always #5 clk = ~clk;

    // Pattern rule: right shift, XOR taps 0xB400 when the dropped bit was set.
    function automatic logic [15:0] ref_next(input logic [15:0] v);
        logic [15:0] t;
        t = v >> 1;
        if (v[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: present rd_empty, pop the model FIFO on rd_en, drive rd_data one cycle later.
    task automatic step();
        logic [15:0] v;
        bit          popped;
        popped   = 1'b0;
        v        = 16'h0;
        rd_empty = (fifo_q.size() == 0) || hole || ($urandom_range(99) < stall_pct);
        #1;
        if (rd_en) begin
            chk("no_pop_when_empty", 32'(rd_empty), 32'd0);
            chk("no_pop_during_abort", 32'(abort), 32'd0);
            if (!rd_empty) begin
                v      = fifo_q.pop_front();
                popped = 1'b1;
                pops++;
            end
        end
        @(posedge clk);
        #1;
        rd_data = popped ? v : 16'($urandom);
    endtask

    task automatic run_test(input string tag, input vec_t t);
        logic [15:0] exp_words[$];
        logic [15:0] w;
        fifo_q.delete();
        w = 16'hACE1;
        for (int k = 0; k < t.nw; k++) begin
            exp_words.push_back(w);
            fifo_q.push_back((k == t.corrupt) ? (w ^ 16'h0001) : w);
            w = ref_next(w);
        end
        stall_pct = t.spct;
        pops      = 0;
        num_words = 32'(t.nw);
        start     = 1'b1;
        step();
        start     = 1'b0;
        num_words = $urandom;
        chk({tag, ".busy_after_start"}, 32'(busy), 32'(t.nw != 0));
        chk({tag, ".done_after_start"}, 32'(done), 32'(t.nw == 0));
        for (int c = 0; c < 5000 && !done; c++) begin
            hole  = (t.hole_at >= 0) && (c >= t.hole_at) && (c < t.hole_at + 20);
            abort = (t.abort_after >= 0) && (pops >= t.abort_after);
            step();
        end
        hole  = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        abort = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'(t.e_pass));
        chk({tag, ".aborted"}, 32'(aborted), 32'(t.e_ab));
        chk({tag, ".word_count"}, word_count, 32'(t.e_wc));
        chk({tag, ".pops"}, 32'(pops), 32'(t.e_wc));
        chk({tag, ".err_count"}, 32'(err_count), 32'(t.e_err));
        if (t.e_err > 0) begin
            chk({tag, ".first_err_index"}, first_err_index, 32'(t.corrupt));
            chk({tag, ".first_err_exp"}, 32'(first_err_exp), 32'(exp_words[t.corrupt]));
            chk({tag, ".first_err_act"}, 32'(first_err_act), 32'(exp_words[t.corrupt] ^ 16'h0001));
        end else begin
            chk({tag, ".first_err_index_clear"}, first_err_index, 32'd0);
        end
    endtask

    initial begin
        vec_t r;
        int   ab;
        //            nw   corrupt abort spct hole  pass wc   err ab
        vecs[0] = '{  8,  -1,     -1,   0,   -1,   1,   8,   0,  0};
        vecs[1] = '{  8,   5,     -1,   0,   -1,   0,   8,   1,  0};
        vecs[2] = '{  8,  -1,     -1,   0,    3,   1,   8,   0,  0};
        vecs[3] = '{100,  -1,     40,  30,   -1,   0,  40,   0,  1};
        vecs[4] = '{  0,  -1,     -1,   0,   -1,   1,   0,   0,  0};
        vecs[5] = '{300, 299,     -1,  50,   -1,   0, 300,   1,  0};
        vecs[6] = '{ 64,  -1,     64,  40,   -1,   1,  64,   0,  0};
        vecs[7] = '{  3,   0,     -1,  20,   -1,   0,   3,   1,  0};
        vecs[8] = '{ 50,  10,     20,  20,   -1,   0,  20,   1,  1};

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        num_words = 32'd0;
        rd_empty  = 1'b1;
        rd_data   = 16'h0;
        hole      = 1'b0;
        stall_pct = 0;
        pops      = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.aborted", 32'(aborted), 32'd0);
        chk("rst.word_count", word_count, 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
        chk("rst.first_err_index", first_err_index, 32'd0);
        chk("rst.rd_en", 32'(rd_en), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_test($sformatf("vec%0d", i), vecs[i]);

        // Randomized runs; expectations follow the spec's rules directly.
        for (int n = 0; n < 6; n++) begin
            r.nw          = int'($urandom_range(150, 1));
            r.corrupt     = int'($urandom_range(r.nw + 20, 0));
            ab            = ($urandom_range(1, 0) == 1) ? int'($urandom_range(r.nw - 1, 0)) : -1;
            r.abort_after = ab;
            r.spct        = $urandom_range(60, 0);
            r.hole_at     = -1;
            r.e_ab        = (ab >= 0);
            r.e_wc        = (ab >= 0) ? ab : r.nw;
            r.e_err       = (r.corrupt < r.e_wc) ? 1 : 0;
            r.e_pass      = !r.e_ab && (r.e_err == 0);
            run_test($sformatf("rnd%0d", n), r);
        end

        // start + abort together in DONE: start wins, abort then drains an empty run.
        fifo_q.delete();
        for (int k = 0; k < 20; k++) fifo_q.push_back(16'h0);
        stall_pct = 0;
        pops      = 0;
        num_words = 32'd20;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start = 1'b0;
        chk("sa.busy_after_start", 32'(busy), 32'd1);
        chk("sa.aborted_cleared", 32'(aborted), 32'd0);
        for (int c = 0; c < 50 && !done; c++) step();
        abort = 1'b0;
        chk("sa.done", 32'(done), 32'd1);
        chk("sa.aborted", 32'(aborted), 32'd1);
        chk("sa.word_count", word_count, 32'd0);
        chk("sa.pass", 32'(pass), 32'd0);
        chk("sa.pops", 32'(pops), 32'd0);

        // Asynchronous reset in the middle of a run, then a clean run.
        fifo_q.delete();
        begin
            logic [15:0] w;
            w = 16'hACE1;
            for (int k = 0; k < 50; k++) begin
                fifo_q.push_back(w ^ 16'h0100);
                w = ref_next(w);
            end
        end
        pops      = 0;
        num_words = 32'd50;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("mid.busy", 32'(busy), 32'd1);
        chk("mid.word_count_nonzero", 32'(word_count != 0), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.word_count", word_count, 32'd0);
        chk("mid_rst.err_count", 32'(err_count), 32'd0);
        chk("mid_rst.first_err_act", 32'(first_err_act), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_test("post_rst", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
